// File: rtl/sr_pkg.sv
// ---------------------------------------------------------------------------
// sr_pkg
//   Shared definitions for the SR latch write driver.
//
//   Contents:
//     sr_state_e  - driver FSM state encoding
//     cnt_width() - width of the shared PULSE/SETTLE down-counter
// ---------------------------------------------------------------------------
package sr_pkg;

    // Fixed encodings: the latch bank debug taps decode these values, so
    // keep them explicit rather than letting the tool pick.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_SETTLE = 2'd2
    } sr_state_e;

    // Counter must hold the larger of the two phase lengths. A settle
    // length of zero still needs a legal (>=1 bit) counter.
    function automatic int cnt_width(input int pulse_cycles, input int settle_cycles);
        int m;
        m = (pulse_cycles > settle_cycles) ? pulse_cycles : settle_cycles;
        if (m < 1) begin
            return 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// ---------------------------------------------------------------------------
// sr_pulse_timer
//   Loadable down-counter shared by the PULSE and SETTLE phases.
//   The owner loads it on entry to a phase; it then counts down and stops
//   at 1 (never wraps). done is high while the count is at (or below) 1,
//   i.e. during the final cycle of the phase.
//
//   Ports:
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous reset, active-low (count -> 0)
//     load      in   load load_val this cycle (has priority over counting)
//     load_val  in   phase length in cycles
//     done      out  current cycle is the last one of the loaded phase
// ---------------------------------------------------------------------------
module sr_pulse_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q > CW'(1)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // A count of 0 only exists out of reset; treat it as expired so a
    // stale counter can never stall the FSM.
    assign done = (cnt_q <= CW'(1));

endmodule

// File: rtl/sr_latch_driver.sv
// ---------------------------------------------------------------------------
// sr_latch_driver
//   Clocked write-side driver for a bank of cross-coupled NOR SR latches.
//   A valid/ready word write is turned into per-bit set/reset pulses that
//   only touch the bits that actually change. s and r are never high on
//   the same bit, stay frozen for the whole pulse window, and are followed
//   by an s=r=0 settle gap so every latch is back in hold before the next
//   write is accepted.
//
//   Parameters:
//     WIDTH          latches driven per write
//     PULSE_CYCLES   cycles s/r stay asserted per write (>=1)
//     SETTLE_CYCLES  cycles of s=r=0 after a pulse (>=0)
//     INIT           shadow value loaded at reset
//
//   Ports:
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous reset, active-low
//     wr_valid  in   write request
//     wr_data   in   desired latch contents
//     wr_ready  out  write can be accepted this cycle
//     s         out  per-latch set pulses (registered)
//     r         out  per-latch reset pulses (registered)
//     q_shadow  out  driver's record of the latch contents
//     busy      out  a pulse or settle gap is in progress
// ---------------------------------------------------------------------------
module sr_latch_driver
    import sr_pkg::*;
#(
    parameter int               WIDTH         = 4,
    parameter int               PULSE_CYCLES  = 2,
    parameter int               SETTLE_CYCLES = 1,
    parameter logic [WIDTH-1:0] INIT          = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q_shadow,
    output logic             busy
);

    localparam int CW = cnt_width(PULSE_CYCLES, SETTLE_CYCLES);

    // -----------------------------------------------------------------------
    // State and registers
    // -----------------------------------------------------------------------
    sr_state_e        state_q, state_d;
    logic             armed_q;      // low during reset and until the first edge after release
    logic [WIDTH-1:0] data_q;       // word captured at accept, committed to the shadow at pulse end
    logic [WIDTH-1:0] s_q, r_q;
    logic [WIDTH-1:0] shadow_q;

    // -----------------------------------------------------------------------
    // Control strobes from the FSM
    // -----------------------------------------------------------------------
    logic             accept;
    logic             need_pulse;
    logic             pulse_start;
    logic             pulse_end;
    logic             tmr_load;
    logic [CW-1:0]    tmr_val;
    logic             tmr_done;

    // -----------------------------------------------------------------------
    // Per-bit change masks. Bits already at the requested value get neither
    // set nor reset, so a latch that does not change is never disturbed.
    // set_m and clr_m are disjoint by construction, which is what keeps
    // s & r == 0 at the latch inputs.
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] set_m, clr_m;

    for (genvar i = 0; i < WIDTH; i++) begin : g_mask
        assign set_m[i] =  wr_data[i] & ~shadow_q[i];
        assign clr_m[i] = ~wr_data[i] &  shadow_q[i];
    end

    assign need_pulse = |(set_m | clr_m);

    // -----------------------------------------------------------------------
    // Handshake
    // -----------------------------------------------------------------------
    assign wr_ready = armed_q && (state_q == ST_IDLE);
    assign accept   = wr_valid && wr_ready;

    // -----------------------------------------------------------------------
    // Phase timer (shared between PULSE and SETTLE)
    // -----------------------------------------------------------------------
    sr_pulse_timer #(
        .CW (CW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and control strobes
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        pulse_start = 1'b0;
        pulse_end   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // A write that changes nothing is still consumed, it just
                // produces no pulse and the driver stays available.
                if (accept && need_pulse) begin
                    pulse_start = 1'b1;
                    tmr_load    = 1'b1;
                    tmr_val     = CW'(PULSE_CYCLES);
                    state_d     = ST_PULSE;
                end
            end

            ST_PULSE: begin
                if (tmr_done) begin
                    pulse_end = 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = CW'(SETTLE_CYCLES);
                        state_d  = ST_SETTLE;
                    end
                end
            end

            ST_SETTLE: begin
                if (tmr_done) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Ready arming: wr_ready is held low through reset and comes up on the
    // first clock edge after release.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
        end else begin
            armed_q <= 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // s/r drive registers. Loaded once at pulse start and cleared once at
    // pulse end; nothing else touches them, so they cannot change inside a
    // pulse window and are zero through SETTLE and IDLE.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= '0;
            r_q <= '0;
        end else if (pulse_start) begin
            s_q <= set_m;
            r_q <= clr_m;
        end else if (pulse_end) begin
            s_q <= '0;
            r_q <= '0;
        end
    end

    // -----------------------------------------------------------------------
    // Captured write data. Only sampled at accept, so upstream may change
    // wr_data freely while the driver is busy.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= INIT;
        end else if (pulse_start) begin
            data_q <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Shadow of the latch contents. Updated only when the pulse has been
    // held for its full length, i.e. when the latches are known to have
    // flipped. A no-op write needs no update since the shadow already
    // matches.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= INIT;
        end else if (pulse_end) begin
            shadow_q <= data_q;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign s        = s_q;
    assign r        = r_q;
    assign q_shadow = shadow_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sr_latch_driver.sv
// ---------------------------------------------------------------------------
// tb_sr_latch_driver
//   Directed scenarios followed by random writes against a word-level
//   reference model: the model only tracks what the latches should hold and
//   derives the expected per-cycle s/r/ready/busy profile of each write from
//   the phase lengths.
// ---------------------------------------------------------------------------
module tb_sr_latch_driver;

    localparam int               W  = 4;
    localparam int               PC = 2;
    localparam int               SC = 1;
    localparam logic [W-1:0]     IV = '0;

    logic         clk;
    logic         rst_n;
    logic         wr_valid;
    logic [W-1:0] wr_data;
    logic         wr_ready;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic [W-1:0] q_shadow;
    logic         busy;

    int           checks = 0;
    int           errors = 0;

    // Reference model state: what the latch bank should currently hold.
    logic [W-1:0] m_shadow;
    // Upstream behaviour while the driver is busy:
    //   0 = quiet, 1 = random junk on valid/data, 2 = hold pend_data valid
    int           noise;
    logic [W-1:0] pend_data;

    sr_latch_driver #(
        .WIDTH         (W),
        .PULSE_CYCLES  (PC),
        .SETTLE_CYCLES (SC),
        .INIT          (IV)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .s        (s),
        .r        (r),
        .q_shadow (q_shadow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [W-1:0] es, input logic [W-1:0] er,
                           input logic [W-1:0] eq, input logic erdy, input logic ebusy);
        chk({tag, ".s"},     32'(s),        32'(es));
        chk({tag, ".r"},     32'(r),        32'(er));
        chk({tag, ".q"},     32'(q_shadow), 32'(eq));
        chk({tag, ".ready"}, 32'(wr_ready), 32'(erdy));
        chk({tag, ".busy"},  32'(busy),     32'(ebusy));
    endtask

    // Advance one cycle and land 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upstream_noise();
        if (noise == 1) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = W'($urandom_range(0, 15));
        end else if (noise == 2) begin
            wr_valid = 1'b1;
            wr_data  = pend_data;
        end
    endtask

    // One complete write from the model's point of view: expected pulse
    // masks are the bits that must rise / fall, held PC cycles, then SC
    // quiet cycles, then ready again with the new contents recorded.
    task automatic write_word(input logic [W-1:0] d);
        logic [W-1:0] es, er;
        es = d & ~m_shadow;
        er = ~d & m_shadow;
        chk("pre_ready", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
        if (d == m_shadow) begin
            chk_out("nop", '0, '0, m_shadow, 1'b1, 1'b0);
        end else begin
            for (int i = 0; i < PC; i++) begin
                chk_out("pulse", es, er, m_shadow, 1'b0, 1'b1);
                chk("s_and_r", 32'(s & r), 32'd0);
                upstream_noise();
                step();
            end
            m_shadow = d;
            for (int j = 0; j < SC; j++) begin
                chk_out("settle", '0, '0, d, 1'b0, 1'b1);
                upstream_noise();
                step();
            end
            chk_out("idle", '0, '0, d, 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_data   = '0;
        noise     = 0;
        pend_data = '0;
        m_shadow  = IV;

        // Reset: outputs idle, ready held low until after release.
        step();
        step();
        chk_out("reset", '0, '0, IV, 1'b0, 1'b0);
        rst_n = 1'b1;
        chk("release_ready", 32'(wr_ready), 32'd0);
        step();
        chk("armed_ready", 32'(wr_ready), 32'd1);

        // Set-only write, then mixed set/clear with a held follow-up write.
        write_word(4'b1010);
        noise     = 2;
        pend_data = 4'b1111;
        write_word(4'b0110);
        // Held request is accepted only now; junk on the bus mid-pulse.
        noise = 1;
        write_word(4'b1111);
        // Same value again: consumed with no pulse.
        noise = 0;
        write_word(4'b1111);
        chk("nop_busy_stays_low", 32'(busy), 32'd0);

        // Reset in the first pulse cycle: clear-only write 1111 -> 1100.
        wr_valid = 1'b1;
        wr_data  = 4'b1100;
        step();
        wr_valid = 1'b0;
        chk("mid_pulse.r", 32'(r), 32'(4'b0011));
        #1 rst_n = 1'b0;
        #1;
        chk_out("async_rst", '0, '0, IV, 1'b0, 1'b0);
        m_shadow = IV;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("rearm_ready", 32'(wr_ready), 32'd1);
        write_word(4'b0001);

        // Random writes with junk upstream activity while busy.
        noise = 1;
        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] d;
            if ($urandom_range(0, 3) == 0) d = m_shadow;
            else                           d = W'($urandom_range(0, 15));
            write_word(d);
        end
        wr_valid = 1'b0;
        step();
        chk("final_q", 32'(q_shadow), 32'(m_shadow));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
